// File: rtl/lab5_rr_encoder_pkg.sv
// lab5_rr_encoder_pkg
// Shared constants, FSM state type and a one-hot helper for the 8-to-3
// round-robin request encoder.
package lab5_rr_encoder_pkg;

  localparam int N_REQ     = 8;
  localparam int CODE_BITS = 3;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_BITS-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lab5_rr_encoder_if.sv
// lab5_rr_encoder_if
// Request/grant bundle between the request sources, the encoder and the
// consumer of the binary select.
//   req     : request pulses, any number of bits per cycle
//   ready   : consumer accepts code while valid is high
//   code    : granted index
//   valid   : code holds a granted index
//   pending : registered pending requests
//   overrun : one-cycle pulse, request hit an already pending bit
// master = encoder side, slave = source/consumer side.
interface lab5_rr_encoder_if import lab5_rr_encoder_pkg::*; ();

  logic [N_REQ-1:0]     req;
  logic                 ready;
  logic [CODE_BITS-1:0] code;
  logic                 valid;
  logic [N_REQ-1:0]     pending;
  logic                 overrun;

  modport master (
    input  req,
    input  ready,
    output code,
    output valid,
    output pending,
    output overrun
  );

  modport slave (
    output req,
    output ready,
    input  code,
    input  valid,
    input  pending,
    input  overrun
  );

endinterface

// File: rtl/lab5_rr_encoder_pick.sv
// lab5_rr_pick
// Combinational selector. With RR=1 it returns the first set bit of
// pending scanning upward from ptr (wrapping 7 -> 0); with RR=0 it returns
// the lowest set bit and ignores ptr.
//   pending : candidate requests
//   ptr     : round-robin start position
//   sel     : selected index (meaningful only when any is high)
//   any     : at least one bit of pending is set
module lab5_rr_pick import lab5_rr_encoder_pkg::*; #(
  parameter bit RR = 1'b1
) (
  input  logic [N_REQ-1:0]     pending,
  input  logic [CODE_BITS-1:0] ptr,
  output logic [CODE_BITS-1:0] sel,
  output logic                 any
);

  logic [CODE_BITS-1:0] base;
  logic [2*N_REQ-1:0]   dbl;
  logic [N_REQ-1:0]     rot;
  logic [CODE_BITS-1:0] off;

  always_comb begin
    base = RR ? ptr : '0;
    // Rotate right by base: bit 0 of rot is pending[base].
    dbl  = {pending, pending} >> base;
    rot  = dbl[N_REQ-1:0];
    off  = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = CODE_BITS'(i);
    end
    // 3-bit add wraps mod 8 for free.
    sel = base + off;
    any = |pending;
  end

endmodule

// File: rtl/lab5_rr_encoder.sv
// lab5_rr_encoder
// Registered 8-to-3 request encoder. Request pulses accumulate in a
// pending register; one index at a time is presented on code/valid and
// removed from pending when the consumer accepts it.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : master side of lab5_rr_encoder_if (req/ready in,
//         code/valid/pending/overrun out, all outputs registered)
//
// state     | meaning
// ----------+----------------------------------------------
// S_IDLE    | nothing presented; latch a pick if pending != 0
// S_PRESENT | code/valid held until ready accepts it
module lab5_rr_encoder import lab5_rr_encoder_pkg::*; #(
  parameter int N      = N_REQ,
  parameter int CODE_W = CODE_BITS,
  parameter bit RR     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  lab5_rr_encoder_if.master bus
);

  // The interface widths are fixed, so any other geometry is a build error.
  if (N != N_REQ || CODE_W != $clog2(N)) begin : g_param_check
    $error("lab5_rr_encoder supports only N=8, CODE_W=3");
  end

  state_t               state, state_next;
  logic [N_REQ-1:0]     pend_q;
  logic [CODE_BITS-1:0] code_q;
  logic [CODE_BITS-1:0] ptr_q;
  logic                 ovr_q;

  logic [CODE_BITS-1:0] sel;
  logic                 any;
  logic                 accept;
  logic                 latch;
  logic [N_REQ-1:0]     clr_mask;

  // Selection sees only the registered pending, never this cycle's req.
  lab5_rr_pick #(.RR(RR)) u_pick (
    .pending (pend_q),
    .ptr     (ptr_q),
    .sel     (sel),
    .any     (any)
  );

  always_comb begin
    accept   = (state == S_PRESENT) && bus.ready;
    clr_mask = accept ? onehot(code_q) : '0;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any) begin
          state_next = S_PRESENT;
          latch      = 1'b1;
        end
      end
      S_PRESENT: begin
        if (bus.ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pend_q <= '0;
      code_q <= '0;
      ptr_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_next;
      // Set wins over the accept clear on the same bit.
      pend_q <= (pend_q & ~clr_mask) | bus.req;
      if (latch)  code_q <= sel;
      if (accept) ptr_q  <= code_q + 3'd1;
      // A re-request on the bit being accepted is a fresh request, not an overrun.
      ovr_q  <= |(bus.req & pend_q & ~clr_mask);
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = (state == S_PRESENT);
  assign bus.pending = pend_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_lab5_rr_encoder.sv
// tb_lab5_rr_encoder
// Drives the same directed stimulus into a round-robin instance and a
// fixed-priority instance; a behavioural model predicts both every cycle,
// and directed scenarios pin grant orders with literal values.
module tb_lab5_rr_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ready;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  lab5_rr_encoder_if if_rr ();
  lab5_rr_encoder_if if_fp ();

  assign if_rr.req   = req;
  assign if_rr.ready = ready;
  assign if_fp.req   = req;
  assign if_fp.ready = ready;

  lab5_rr_encoder #(.RR(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  lab5_rr_encoder #(.RR(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model (index 0 = RR, 1 = fixed) ----------
  int m_pend  [2];
  int m_code  [2];
  int m_ptr   [2];
  bit m_valid [2];
  bit m_ovr   [2];

  function automatic int pick_model(int pend, int ptr, bit rr);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = rr ? (ptr + k) % 8 : k;
      if (((pend >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 0; m_code[m] = 0; m_ptr[m] = 0; m_valid[m] = 0; m_ovr[m] = 0;
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int clr;
      int s;
      bit acc;
      if (rst) begin
        m_pend[m] = 0; m_code[m] = 0; m_ptr[m] = 0; m_valid[m] = 0; m_ovr[m] = 0;
      end else begin
        acc = m_valid[m] && ready;
        clr = acc ? (1 << m_code[m]) : 0;
        m_ovr[m] = ((int'(req) & m_pend[m] & ~clr) & 8'hFF) != 0;
        if (!m_valid[m]) begin
          s = pick_model(m_pend[m], m_ptr[m], m == 0);
          if (s >= 0) begin
            m_code[m]  = s;
            m_valid[m] = 1'b1;
          end
        end else if (acc) begin
          m_valid[m] = 1'b0;
          m_ptr[m]   = (m_code[m] + 1) % 8;
        end
        m_pend[m] = ((m_pend[m] & ~clr) | int'(req)) & 8'hFF;
      end
    end
  end

  // ---------------- checking helpers --------------------------------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input int m, input int code,
                          input int valid, input int pend, input int ovr);
    check({tag, " valid"},   valid, int'(m_valid[m]));
    check({tag, " pending"}, pend,  m_pend[m]);
    check({tag, " overrun"}, ovr,   int'(m_ovr[m]));
    if (m_valid[m]) check({tag, " code"}, code, m_code[m]);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_inst("rr", 0, int'(if_rr.code), int'(if_rr.valid), int'(if_rr.pending), int'(if_rr.overrun));
      cmp_inst("fp", 1, int'(if_fp.code), int'(if_fp.valid), int'(if_fp.pending), int'(if_fp.overrun));
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic cycle(input logic [7:0] r, input logic rd, input logic rs);
    @(negedge clk);
    req   = r;
    ready = rd;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
  endtask

  int q_rr[$];
  int q_fp[$];
  int t_rr[$];

  // Holds ready high with no new requests and logs each presented code.
  task automatic capture(input int n);
    q_rr.delete(); q_fp.delete(); t_rr.delete();
    for (int i = 0; i < n; i++) begin
      if (if_rr.valid) begin q_rr.push_back(int'(if_rr.code)); t_rr.push_back(i); end
      if (if_fp.valid) q_fp.push_back(int'(if_fp.code));
      cycle(8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[$]);
    check({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s grant%0d", name, i), got[i], exp[i]);
  endtask

  // ---------------- directed scenarios ------------------------------------
  initial begin
    rst = 1'b1; req = 8'h00; ready = 1'b0;
    @(posedge clk);
    armed = 1'b1;
    do_reset();
    check("reset valid",   int'(if_rr.valid),   0);
    check("reset code",    int'(if_rr.code),    0);
    check("reset pending", int'(if_rr.pending), 0);
    check("reset overrun", int'(if_rr.overrun), 0);

    // Single request on bit 2.
    cycle(8'h04, 1'b0, 1'b0);
    check("t1 pending set", int'(if_rr.pending), 8'h04);
    check("t1 valid early", int'(if_rr.valid),   0);
    cycle(8'h00, 1'b0, 1'b0);
    check("t1 valid",       int'(if_rr.valid),   1);
    check("t1 code",        int'(if_rr.code),    2);
    cycle(8'h00, 1'b1, 1'b0);
    check("t1 accept valid",   int'(if_rr.valid),   0);
    check("t1 accept pending", int'(if_rr.pending), 0);

    // All eight requests at once, ready held high.
    do_reset();
    cycle(8'hFF, 1'b1, 1'b0);
    capture(20);
    check_seq("t2 rr", q_rr, '{0, 1, 2, 3, 4, 5, 6, 7});
    check_seq("t2 fp", q_fp, '{0, 1, 2, 3, 4, 5, 6, 7});
    for (int i = 1; i < t_rr.size(); i++)
      check($sformatf("t2 spacing%0d", i), t_rr[i] - t_rr[i-1], 2);
    check("t2 drained valid", int'(if_rr.valid), 0);

    // Wrap-around from ptr 6.
    do_reset();
    cycle(8'h20, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    check("t3 code5", int'(if_rr.code), 5);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h83, 1'b1, 1'b0);
    capture(10);
    check_seq("t3 rr", q_rr, '{7, 0, 1});
    check_seq("t3 fp", q_fp, '{0, 1, 7});

    // New request arriving while code 4 is presented.
    do_reset();
    cycle(8'h90, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    check("t4 code4", int'(if_fp.code), 4);
    cycle(8'h02, 1'b0, 1'b0);
    check("t4 hold code",    int'(if_fp.code),    4);
    check("t4 pending grew", int'(if_fp.pending), 8'h92);
    cycle(8'h00, 1'b0, 1'b0);
    check("t4 still code4", int'(if_fp.code), 4);
    capture(10);
    check_seq("t4 fp", q_fp, '{4, 1, 7});
    check_seq("t4 rr", q_rr, '{4, 7, 1});

    // Overrun, then clear-and-set on the accept cycle.
    do_reset();
    cycle(8'h08, 1'b0, 1'b0);
    check("t5 no overrun first", int'(if_rr.overrun), 0);
    cycle(8'h08, 1'b0, 1'b0);
    check("t5 overrun",   int'(if_rr.overrun), 1);
    check("t5 pending3",  int'(if_rr.pending), 8'h08);
    cycle(8'h00, 1'b0, 1'b0);
    check("t5 overrun pulse", int'(if_rr.overrun), 0);
    cycle(8'h08, 1'b1, 1'b0);
    check("t5 accept overrun", int'(if_rr.overrun), 0);
    check("t5 accept pending", int'(if_rr.pending), 8'h08);
    cycle(8'h00, 1'b0, 1'b0);
    check("t5 represent valid", int'(if_rr.valid), 1);
    check("t5 represent code",  int'(if_rr.code),  3);

    // Reset while presenting with 8'h81 pending.
    do_reset();
    cycle(8'h81, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    check("t6 presenting", int'(if_rr.valid), 1);
    cycle(8'h00, 1'b0, 1'b1);
    check("t6 rst valid",   int'(if_rr.valid),   0);
    check("t6 rst code",    int'(if_rr.code),    0);
    check("t6 rst pending", int'(if_rr.pending), 0);
    check("t6 rst overrun", int'(if_rr.overrun), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b1, 1'b0);
      check("t6 no grant", int'(if_rr.valid) + int'(if_fp.valid), 0);
    end

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab5_rr_encoder.md
# lab5_rr_encoder

Registered 8-to-3 request encoder; the inverse of the team's 3-to-8 one-hot select decoder. Collects request pulses on 8 one-hot-style lines into a pending register and emits one 3-bit index at a time over a valid/ready handshake. Selection is round-robin or fixed priority. Sits between the request sources and any consumer that drives an 8-way one-hot decoder from a binary select.

## Interface

- `N`, 8: number of request lines. Fixed at 8 for this block.
- `CODE_W`, 3: index width. Must equal clog2(N).
- `RR`, 1: 1 selects round-robin; 0 selects fixed priority, bit 0 highest.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: request pulses; any number of bits may be high in a cycle.
- `ready` in 1: consumer accepts `code` this cycle when `valid` is high.
- `code` out CODE_W: index of the granted request; stable while `valid` is high and `ready` is low.
- `valid` out 1: `code` holds a granted index.
- `pending` out N: registered pending requests, including the bit currently presented.
- `overrun` out 1: one-cycle pulse; a request arrived for a bit that was already pending.

## Operation

- FSM, 2 states:
  - IDLE: if `pending` != 0, latch the selected index into `code`, set `valid`=1, go to PRESENT. Otherwise stay.
  - PRESENT: hold `code`/`valid`. On `ready`=1, clear `pending[code]`, set `valid`=0, update the pointer, go to IDLE.
- Pending update: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of `code` on an accept cycle, 0 otherwise.
  - Set wins: a req on the bit being cleared in the same cycle leaves it pending.
- Selection with RR=1: first set bit of `pending`, scanning upward from `ptr`, wrapping 7 -> 0.
  - On accept, ptr <= code+1 mod 8; ptr wraps 7 -> 0.
- Selection with RR=0: lowest set bit of `pending`; ptr is unused.
- Selection reads only the registered `pending`. A req arriving in the same cycle is not visible to the current decision.
- `overrun` = |(req & pending & ~clr_mask), registered; high for one cycle. The request is not lost, since the bit stays pending. A simultaneous clear-and-set is not an overrun.
- `pending` may change while in PRESENT. `code` must not change until accept.
- `ready` while `valid`=0 is ignored.

## Timing

- Reset values: `pending`=0, `code`=0, `valid`=0, `overrun`=0, ptr=0, state IDLE.
- Reset mid-handshake discards all pending requests and the presented code; there is no accept.
- Latency:
  - req sampled at edge t -> `pending` bit set after t.
  - `valid` rises after edge t+1 if the block was idle.
- Throughput: one grant per 2 cycles maximum (PRESENT -> IDLE bubble) when `ready` is held high.
- `ready` combinational to `valid` is not required. No output depends combinationally on inputs; all outputs are registered.

## Structure

- Shared header `lab5_defs.vh`:
  - state encodings: localparam S_IDLE=1'b0, S_PRESENT=1'b1.
  - N_REQ=8 and CODE_W=3 defaults.
- Sub-module `lab5_rr_pick`: purely combinational.
  - Inputs: `pending`, `ptr`, `RR`.
  - Outputs: selected index and an `any` flag.
  - Implementation: rotate right by ptr, find the first set bit, add ptr mod 8.
- Top level holds the FSM, pending/ptr/code registers and overrun logic.

## Test plan

- Reset, then req=8'b0000_0100 for one cycle -> `valid`=1 two edges later with `code`=2; ready=1 -> `pending`=0, `valid`=0 next cycle.
- RR=1, req=8'hFF for one cycle, ready held 1 -> codes 0,1,2,...,7 in order, one every 2 cycles, then `valid` stays 0.
- RR=1, ptr=6 (after granting 5), pending=8'b0000_0011 plus bit 7 -> grants 7, then 0, then 1 (wrap-around).
- RR=0, pending=8'b1001_0000, then req bit 1 during PRESENT(code 4) -> `code` stays 4 until accept; next grant is 1, then 7.
- Overrun and simultaneous events:
  - req bit 3 again while bit 3 is pending but not being accepted -> `overrun` high one cycle, `pending[3]` stays 1.
  - req bit 3 on the accept cycle of code 3 -> no overrun, bit 3 re-presented.
- `rst` asserted in PRESENT with ready=0 and pending=8'h81 -> next cycle all outputs 0; no grant until a new req.
